dbus_router: RTL and testbench

Data-bus address router between the core's load/store port and the simulation peripherals: data RAM, timer, and the simulation console. Decodes each host request, forwards it to exactly one target, and returns exactly one response per granted request. Targets with no response channel (console) and unmapped addresses get a locally generated response. At most one transaction is outstanding at a time.

---
 rtl/dbus_router.sv | 155 +++++++++++++++
 tb/tb_dbus_router.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_router.sv
// dbus_router: routes the core load/store port to data RAM, timer or console.
// Decode and forwarding are combinational. RAM responses pass through with no
// added latency. Console and unmapped accesses answer one cycle after grant.
// Backpressure comes only from ram_gnt; the timer and console take every request.
// Ports: host_* is the core side; ram_*, tmr_* and con_* are the target sides.
module dbus_router #(
    parameter logic [31:0] RAM_BASE = 32'h0010_0000,
    parameter logic [31:0] RAM_MASK = 32'hFFF0_0000,
    parameter logic [31:0] TMR_BASE = 32'h0003_0000,
    parameter logic [31:0] TMR_MASK = 32'hFFFF_FF00,
    parameter logic [31:0] CON_BASE = 32'h0002_0000,
    parameter logic [31:0] CON_MASK = 32'hFFFF_FF00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // host side
    input  logic        host_req_i,
    output logic        host_gnt_o,
    input  logic        host_we_i,
    input  logic [3:0]  host_be_i,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_rvalid_o,
    output logic [31:0] host_rdata_o,
    output logic        host_err_o,
    // data RAM
    output logic        ram_req_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_be_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic        ram_gnt_i,
    input  logic        ram_rvalid_i,
    input  logic [31:0] ram_rdata_i,
    // timer
    output logic        tmr_req_o,
    output logic        tmr_we_o,
    output logic [3:0]  tmr_be_o,
    output logic [31:0] tmr_addr_o,
    output logic [31:0] tmr_wdata_o,
    input  logic        tmr_rvalid_i,
    input  logic [31:0] tmr_rdata_i,
    // console (no response channel)
    output logic        con_req_o,
    output logic        con_we_o,
    output logic [31:0] con_addr_o,
    output logic [31:0] con_wdata_o
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_RAM   = 2'd1,
        WAIT_TMR   = 2'd2,
        RESP_LOCAL = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        err_q, err_nxt;

    logic        sel_ram, sel_tmr, sel_con;
    logic        resp_vld;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        can_issue;
    logic        gnt;

    // Overlap priority RAM > timer > console is folded into the selects,
    // so at most one of them is ever high.
    assign sel_ram = ((host_addr_i & RAM_MASK) == RAM_BASE);
    assign sel_tmr = !sel_ram && ((host_addr_i & TMR_MASK) == TMR_BASE);
    assign sel_con = !sel_ram && !sel_tmr && ((host_addr_i & CON_MASK) == CON_BASE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        err_nxt    = err_q;
        resp_vld   = 1'b0;
        resp_rdata = 32'h0;
        resp_err   = 1'b0;

        // Only the target currently being waited on can produce a response;
        // stray rvalids from the other target are dropped here.
        case (state)
            WAIT_RAM: begin
                resp_vld   = ram_rvalid_i;
                resp_rdata = ram_rvalid_i ? ram_rdata_i : 32'h0;
            end
            WAIT_TMR: begin
                resp_vld   = tmr_rvalid_i;
                resp_rdata = tmr_rvalid_i ? tmr_rdata_i : 32'h0;
            end
            RESP_LOCAL: begin
                resp_vld = 1'b1;
                resp_err = err_q;
            end
            default: ;
        endcase

        // A new request may be accepted in the cycle the previous response
        // leaves, which gives one transaction per cycle on single-cycle targets.
        can_issue = (state == IDLE) || resp_vld;
        gnt       = host_req_i && can_issue && (sel_ram ? ram_gnt_i : 1'b1);

        if (resp_vld)
            state_nxt = IDLE;

        if (gnt) begin
            if (sel_ram)
                state_nxt = WAIT_RAM;
            else if (sel_tmr)
                state_nxt = WAIT_TMR;
            else begin
                state_nxt = RESP_LOCAL;
                err_nxt   = !sel_con;
            end
        end
    end

    // Handshake and response outputs are held low for the whole reset
    // period, even though the decode itself is purely combinational.
    assign host_gnt_o    = gnt && !rst_i;
    assign host_rvalid_o = resp_vld && !rst_i;
    assign host_rdata_o  = rst_i ? 32'h0 : resp_rdata;
    assign host_err_o    = resp_err && !rst_i;

    assign ram_req_o = host_req_i && sel_ram && can_issue && !rst_i;
    assign tmr_req_o = host_req_i && sel_tmr && can_issue && !rst_i;
    assign con_req_o = host_req_i && sel_con && can_issue && !rst_i;

    // Request fields go to every target unchanged; each target only acts on
    // them while its own req is high.
    assign ram_we_o    = host_we_i;
    assign ram_be_o    = host_be_i;
    assign ram_addr_o  = host_addr_i;
    assign ram_wdata_o = host_wdata_i;

    assign tmr_we_o    = host_we_i;
    assign tmr_be_o    = host_be_i;
    assign tmr_addr_o  = host_addr_i;
    assign tmr_wdata_o = host_wdata_i;

    assign con_we_o    = host_we_i;
    assign con_addr_o  = host_addr_i;
    assign con_wdata_o = host_wdata_i;

endmodule

// File: tb/tb_dbus_router.sv
// Directed bench for dbus_router: console, unmapped, RAM wait states,
// timer/console back-to-back, reset mid-transaction and stray responses.
module tb_dbus_router;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        host_req_i;
    logic        host_gnt_o;
    logic        host_we_i;
    logic [3:0]  host_be_i;
    logic [31:0] host_addr_i;
    logic [31:0] host_wdata_i;
    logic        host_rvalid_o;
    logic [31:0] host_rdata_o;
    logic        host_err_o;
    logic        ram_req_o, ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o, ram_wdata_o;
    logic        ram_gnt_i, ram_rvalid_i;
    logic [31:0] ram_rdata_i;
    logic        tmr_req_o, tmr_we_o;
    logic [3:0]  tmr_be_o;
    logic [31:0] tmr_addr_o, tmr_wdata_o;
    logic        tmr_rvalid_i;
    logic [31:0] tmr_rdata_i;
    logic        con_req_o, con_we_o;
    logic [31:0] con_addr_o, con_wdata_o;

    int n_assert = 0;
    int n_fail   = 0;

    dbus_router dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .host_req_i   (host_req_i),
        .host_gnt_o   (host_gnt_o),
        .host_we_i    (host_we_i),
        .host_be_i    (host_be_i),
        .host_addr_i  (host_addr_i),
        .host_wdata_i (host_wdata_i),
        .host_rvalid_o(host_rvalid_o),
        .host_rdata_o (host_rdata_o),
        .host_err_o   (host_err_o),
        .ram_req_o    (ram_req_o),
        .ram_we_o     (ram_we_o),
        .ram_be_o     (ram_be_o),
        .ram_addr_o   (ram_addr_o),
        .ram_wdata_o  (ram_wdata_o),
        .ram_gnt_i    (ram_gnt_i),
        .ram_rvalid_i (ram_rvalid_i),
        .ram_rdata_i  (ram_rdata_i),
        .tmr_req_o    (tmr_req_o),
        .tmr_we_o     (tmr_we_o),
        .tmr_be_o     (tmr_be_o),
        .tmr_addr_o   (tmr_addr_o),
        .tmr_wdata_o  (tmr_wdata_o),
        .tmr_rvalid_i (tmr_rvalid_i),
        .tmr_rdata_i  (tmr_rdata_i),
        .con_req_o    (con_req_o),
        .con_we_o     (con_we_o),
        .con_addr_o   (con_addr_o),
        .con_wdata_o  (con_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then drive new inputs.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Host request presented in the current cycle.
    task automatic host(input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        host_req_i   = req;
        host_we_i    = we;
        host_be_i    = 4'hF;
        host_addr_i  = addr;
        host_wdata_i = wdata;
    endtask

    initial begin
        rst_i        = 1'b1;
        ram_gnt_i    = 1'b1;
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'hFFFF_FFFF;
        tmr_rvalid_i = 1'b1;
        tmr_rdata_i  = 32'hFFFF_FFFF;
        host(1'b1, 1'b0, 32'h0010_0000, 32'h0);

        // Reset: every handshake/response output low regardless of inputs.
        #2;
        chk("rst_gnt",    {31'b0, host_gnt_o},    32'h0);
        chk("rst_rvalid", {31'b0, host_rvalid_o}, 32'h0);
        chk("rst_rdata",  host_rdata_o,           32'h0);
        chk("rst_err",    {31'b0, host_err_o},    32'h0);
        chk("rst_ramreq", {31'b0, ram_req_o},     32'h0);
        chk("rst_tmrreq", {31'b0, tmr_req_o},     32'h0);
        tick();
        ram_gnt_i    = 1'b0;
        ram_rvalid_i = 1'b0;
        tmr_rvalid_i = 1'b0;
        host(1'b0, 1'b0, 32'h0, 32'h0);
        rst_i = 1'b0;

        // Console write of 'A': grant and console req in the same cycle.
        tick();
        host(1'b1, 1'b1, 32'h0002_0004, 32'h41);
        #2;
        chk("con_gnt",    {31'b0, host_gnt_o},    32'h1);
        chk("con_req",    {31'b0, con_req_o},     32'h1);
        chk("con_we",     {31'b0, con_we_o},      32'h1);
        chk("con_addr",   con_addr_o,             32'h0002_0004);
        chk("con_wdata",  con_wdata_o,            32'h41);
        chk("con_ramreq", {31'b0, ram_req_o},     32'h0);
        chk("con_tmrreq", {31'b0, tmr_req_o},     32'h0);
        chk("con_rv0",    {31'b0, host_rvalid_o}, 32'h0);
        tick();
        host(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("con_rv1",    {31'b0, host_rvalid_o}, 32'h1);
        chk("con_err",    {31'b0, host_err_o},    32'h0);
        chk("con_rdata",  host_rdata_o,           32'h0);
        chk("con_req_off", {31'b0, con_req_o},    32'h0);
        tick();
        #2;
        chk("con_rv2",    {31'b0, host_rvalid_o}, 32'h0);

        // Console halt register write.
        host(1'b1, 1'b1, 32'h0002_0008, 32'h1);
        #2;
        chk("halt_gnt",   {31'b0, host_gnt_o},    32'h1);
        chk("halt_req",   {31'b0, con_req_o},     32'h1);
        chk("halt_addr",  con_addr_o,             32'h0002_0008);
        tick();
        host(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("halt_rv",    {31'b0, host_rvalid_o}, 32'h1);
        chk("halt_err",   {31'b0, host_err_o},    32'h0);
        tick();

        // Unmapped read: granted, no target req, error response next cycle.
        host(1'b1, 1'b0, 32'h0000_0000, 32'h0);
        #2;
        chk("um_gnt",     {31'b0, host_gnt_o},    32'h1);
        chk("um_reqs",    {29'b0, ram_req_o, tmr_req_o, con_req_o}, 32'h0);
        tick();
        host(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("um_rv",      {31'b0, host_rvalid_o}, 32'h1);
        chk("um_err",     {31'b0, host_err_o},    32'h1);
        chk("um_rdata",   host_rdata_o,           32'h0);
        tick();
        #2;
        chk("um_rv_off",  {31'b0, host_rvalid_o}, 32'h0);

        // RAM read stalled by ram_gnt_i for three cycles.
        host(1'b1, 1'b0, 32'h0010_0010, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("ram_req_w",  {31'b0, ram_req_o},  32'h1);
            chk("ram_gnt_w",  {31'b0, host_gnt_o}, 32'h0);
            tick();
        end
        ram_gnt_i = 1'b1;
        #2;
        chk("ram_gnt",    {31'b0, host_gnt_o},    32'h1);
        tick();
        host(1'b0, 1'b0, 32'h0, 32'h0);
        ram_gnt_i = 1'b0;
        #2;
        chk("ram_rv_wait", {31'b0, host_rvalid_o}, 32'h0);
        tick();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'hDEAD_BEEF;
        #2;
        chk("ram_rv",     {31'b0, host_rvalid_o}, 32'h1);
        chk("ram_rdata",  host_rdata_o,           32'hDEAD_BEEF);
        chk("ram_err",    {31'b0, host_err_o},    32'h0);
        tick();
        ram_rvalid_i = 1'b0;
        #2;
        chk("ram_rv_off", {31'b0, host_rvalid_o}, 32'h0);

        // Timer read followed directly by a console write.
        host(1'b1, 1'b0, 32'h0003_0004, 32'h0);
        #2;
        chk("b2b_tmrreq", {31'b0, tmr_req_o},     32'h1);
        chk("b2b_gnt1",   {31'b0, host_gnt_o},    32'h1);
        tick();
        tmr_rvalid_i = 1'b1;
        tmr_rdata_i  = 32'h1234_5678;
        host(1'b1, 1'b1, 32'h0002_0004, 32'h42);
        #2;
        chk("b2b_rv1",    {31'b0, host_rvalid_o}, 32'h1);
        chk("b2b_rdata1", host_rdata_o,           32'h1234_5678);
        chk("b2b_gnt2",   {31'b0, host_gnt_o},    32'h1);
        chk("b2b_conreq", {31'b0, con_req_o},     32'h1);
        tick();
        tmr_rvalid_i = 1'b0;
        host(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("b2b_rv2",    {31'b0, host_rvalid_o}, 32'h1);
        chk("b2b_rdata2", host_rdata_o,           32'h0);
        chk("b2b_err2",   {31'b0, host_err_o},    32'h0);
        tick();
        #2;
        chk("b2b_rv_off", {31'b0, host_rvalid_o}, 32'h0);

        // Reset while waiting on RAM drops the pending response.
        host(1'b1, 1'b0, 32'h0010_0020, 32'h0);
        ram_gnt_i = 1'b1;
        #2;
        chk("rr_gnt",     {31'b0, host_gnt_o},    32'h1);
        tick();
        host(1'b0, 1'b0, 32'h0, 32'h0);
        ram_gnt_i = 1'b0;
        rst_i     = 1'b1;
        #2;
        chk("rr_rv_rst",  {31'b0, host_rvalid_o}, 32'h0);
        tick();
        rst_i = 1'b0;
        tick();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'hCAFE_F00D;
        #2;
        chk("rr_late_rv", {31'b0, host_rvalid_o}, 32'h0);
        chk("rr_late_rd", host_rdata_o,           32'h0);
        tick();
        ram_rvalid_i = 1'b0;
        host(1'b1, 1'b0, 32'h0002_0000, 32'h0);
        #2;
        chk("rr_next_gnt", {31'b0, host_gnt_o},   32'h1);
        tick();
        host(1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        chk("rr_next_rv", {31'b0, host_rvalid_o}, 32'h1);
        chk("rr_next_err", {31'b0, host_err_o},   32'h0);
        tick();

        // Stray timer response while idle.
        tmr_rvalid_i = 1'b1;
        tmr_rdata_i  = 32'h5555_AAAA;
        #2;
        chk("stray_rv",   {31'b0, host_rvalid_o}, 32'h0);
        chk("stray_rd",   host_rdata_o,           32'h0);
        tick();
        tmr_rvalid_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
